// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the serial_adder_nb chunked adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  // Step counter width; a single-step build still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; exposes the
// carry into the MSB so the caller can form signed overflow.
module adder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum_c,
  output logic             cout_c,
  output logic             cmsb_c
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fulladder
    assign sum_c[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout_c = c[CHUNK];
  assign cmsb_c = c[CHUNK-1];

endmodule

// File: rtl/serial_adder_nb.sv
// Multi-cycle WIDTH-bit adder processing CHUNK bits per clock with valid/ready
// handshakes. Define SERIAL_ADDER_SUB_EN to add the 'sub' port (in1 - in2).
module serial_adder_nb
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic             carryIn,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] out,
  output logic             carryOut,
  output logic             overflow
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int unsigned STEPS = WIDTH / CHUNK;
  localparam int unsigned CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  adder_state_t     state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] out_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             ovf_q;
  logic             valid_q;

  int unsigned      base_c;
  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] sum_k;
  logic             cout_k;
  logic             cmsb_k;

  // Select the operand slice for the current step.
  assign base_c = 32'(cnt_q) * CHUNK;
  assign a_k    = a_q[base_c +: CHUNK];
  assign b_k    = b_q[base_c +: CHUNK];

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a      (a_k),
    .b      (b_k),
    .cin    (carry_q),
    .sum_c  (sum_k),
    .cout_c (cout_k),
    .cmsb_c (cmsb_k)
  );

  // Sequencer: accept, STEPS chunk additions, then hold result until taken.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inValid) begin
            a_q <= in1;
`ifdef SERIAL_ADDER_SUB_EN
            b_q     <= sub ? ~in2 : in2;
            carry_q <= sub ? 1'b1 : carryIn;
`else
            b_q     <= in2;
            carry_q <= carryIn;
`endif
            out_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          out_q[base_c +: CHUNK] <= sum_k;
          carry_q                <= cout_k;
          if (cnt_q == LAST) begin
            ovf_q   <= cmsb_k ^ cout_k;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (outReady) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign inReady  = (state_q == IDLE);
  assign outValid = valid_q;
  assign out      = out_q;
  assign carryOut = carry_q;
  assign overflow = ovf_q;

endmodule
